// File: rtl/arb_pkg.sv
// Shared types and constants for the four-client round-robin arbiter cell.
package arb_pkg;

  localparam int unsigned N_CLIENTS = 4;
  localparam int unsigned CLIENT_W  = 2;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_REQ  = 2'd1,
    A_ACK  = 2'd2
  } ArbPhase;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning last+1 .. last (mod 4).
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_CLIENTS-1:0] req,
  input  logic [CLIENT_W-1:0]  last,
  output logic [CLIENT_W-1:0]  winner,
  output logic                 any
);

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    logic [CLIENT_W-1:0] idx;
    winner = last;
    any    = |req;
    idx    = '0;
    for (int i = N_CLIENTS; i >= 1; i--) begin
      idx = CLIENT_W'(last + CLIENT_W'(i));
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-phase round-robin arbiter cell; cascades into trees through req0/ack0.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CW       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CLIENTS-1:0] req,
  output logic [N_CLIENTS-1:0] ack,
  output logic                 req0,
  input  logic                 ack0,
  output logic                 hold_err
);

  ArbPhase               state_q, state_d;
  logic [CLIENT_W-1:0]   w_q, w_d;
  logic [CLIENT_W-1:0]   last_q, last_d;
  logic [CW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                  hold_err_q, hold_err_d;
  logic [N_CLIENTS-1:0]  ack_q, ack_d;
  logic                  req0_q, req0_d;
  logic [CLIENT_W-1:0]   pick_w;
  logic                  pick_any;

  rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_w),
    .any    (pick_any)
  );

  // Next-state, hold counter and output decode; outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    hold_err_d = hold_err_q;
    unique case (state_q)
      A_IDLE: begin
        if (pick_any) begin
          w_d     = pick_w;
          state_d = A_REQ;
        end
      end
      A_REQ: begin
        if (ack0) begin
          state_d    = A_ACK;
          hold_cnt_d = '0;
        end
      end
      A_ACK: begin
        if (hold_cnt_q == CW'(MAX_HOLD)) hold_err_d = 1'b1;
        else                             hold_cnt_d = hold_cnt_q + CW'(1);
        if (!req[w_q]) begin
          state_d = A_IDLE;
          last_d  = w_q;
        end
      end
      default: state_d = A_IDLE;
    endcase

    req0_d = (state_d != A_IDLE);
    ack_d  = '0;
    if (state_d == A_ACK) ack_d[w_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= A_IDLE;
      w_q        <= '0;
      last_q     <= CLIENT_W'(N_CLIENTS - 1);
      hold_cnt_q <= '0;
      hold_err_q <= 1'b0;
      ack_q      <= '0;
      req0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      hold_err_q <= hold_err_d;
      ack_q      <= ack_d;
      req0_q     <= req0_d;
    end
  end

  assign ack      = ack_q;
  assign req0     = req0_q;
  assign hold_err = hold_err_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus a randomized run against a reference model.
module tb_rr_arb4;

  localparam int unsigned MAX_HOLD = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic       req0;
  logic       ack0;
  logic       ack0_drv;
  logic       tie_root;
  logic       hold_err;

  int n_checks;
  int n_fail;

  assign ack0 = tie_root ? req0 : ack0_drv;

  rr_arb4 #(.MAX_HOLD(MAX_HOLD), .CW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .req0     (req0),
    .ack0     (ack0),
    .hold_err (hold_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    tie_root = 1'b1;
    ack0_drv = 1'b0;
    do_reset();
    n_checks++;
    if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_checks++;
    if (req0 !== 1'b0) begin n_fail++; $display("FAIL reset_req0: got %b want 0", req0); end
    n_checks++;
    if (hold_err !== 1'b0) begin n_fail++; $display("FAIL reset_hold_err: got %b want 0", hold_err); end
  endtask

  task automatic test_basic;
    do_reset();
    tie_root = 1'b1;
    req = 4'b0001;
    tick();
    n_checks++;
    if (req0 !== 1'b1 || ack !== 4'b0000) begin
      n_fail++; $display("FAIL basic_edge1: req0=%b ack=%b want req0=1 ack=0000", req0, ack);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL basic_edge2: got %b want 0001", ack); end
    req = 4'b0000;
    tick();
    n_checks++;
    if (ack !== 4'b0000 || req0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: req0=%b ack=%b want 0/0000", req0, ack);
    end
  endtask

  task automatic test_rotation;
    int n_grants;
    int idx;
    logic [3:0] prev_ack;
    do_reset();
    tie_root = 1'b1;
    req      = 4'b1111;
    n_grants = 0;
    prev_ack = 4'b0000;
    for (int cyc = 0; cyc < 60 && n_grants < 5; cyc++) begin
      tick();
      n_checks++;
      if ($countones(ack) > 1) begin n_fail++; $display("FAIL rot_onehot: got %b", ack); end
      if (ack != 4'b0000 && prev_ack == 4'b0000) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
        n_checks++;
        if (idx != n_grants % 4) begin
          n_fail++; $display("FAIL rot_order: grant %0d got client %0d want %0d", n_grants, idx, n_grants % 4);
        end
        n_grants++;
        req[idx] = 1'b0;
      end else if (ack == 4'b0000 && prev_ack != 4'b0000) begin
        req = 4'b1111;
      end
      prev_ack = ack;
    end
    n_checks++;
    if (n_grants != 5) begin n_fail++; $display("FAIL rot_timeout: got %0d grants want 5", n_grants); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_non_root;
    do_reset();
    tie_root = 1'b0;
    ack0_drv = 1'b0;
    req      = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (ack !== 4'b0000 || req0 !== 1'b1) begin
        n_fail++; $display("FAIL nonroot_wait%0d: ack=%b req0=%b want 0000/1", i, ack, req0);
      end
    end
    ack0_drv = 1'b1;
    tick();
    n_checks++;
    if (ack !== 4'b0100) begin n_fail++; $display("FAIL nonroot_grant: got %b want 0100", ack); end
    req      = 4'b0000;
    ack0_drv = 1'b0;
    tick();
    n_checks++;
    if (ack !== 4'b0000 || req0 !== 1'b0) begin
      n_fail++; $display("FAIL nonroot_release: ack=%b req0=%b want 0000/0", ack, req0);
    end
  endtask

  task automatic test_hold;
    do_reset();
    tie_root = 1'b1;
    req      = 4'b0001;
    tick();
    tick();
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if (ack !== 4'b0001 || hold_err !== (k >= 17)) begin
        n_fail++; $display("FAIL hold_cycle%0d: ack=%b hold_err=%b want 0001/%0d", k, ack, hold_err, k >= 17);
      end
      if (k < 20) tick();
    end
    req = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (ack !== 4'b0000 || hold_err !== 1'b1) begin
      n_fail++; $display("FAIL hold_sticky: ack=%b hold_err=%b want 0000/1", ack, hold_err);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    tie_root = 1'b1;
    req      = 4'b0010;
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (ack !== 4'b0010 || hold_err !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: ack=%b hold_err=%b want 0010/1", ack, hold_err);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (ack !== 4'b0000 || req0 !== 1'b0 || hold_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_post: ack=%b req0=%b hold_err=%b want 0000/0/0", ack, req0, hold_err);
    end
    req = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL rstmid_regrant: got %b want 0001", ack); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_ack0_glitch;
    do_reset();
    tie_root = 1'b0;
    ack0_drv = 1'b1;
    req      = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (ack !== 4'b0000 || req0 !== 1'b0) begin
      n_fail++; $display("FAIL glitch_idle: ack=%b req0=%b want 0000/0", ack, req0);
    end
    ack0_drv = 1'b0;
    req      = 4'b1000;
    tick();
    ack0_drv = 1'b1;
    tick();
    n_checks++;
    if (ack !== 4'b1000) begin n_fail++; $display("FAIL glitch_grant: got %b want 1000", ack); end
    ack0_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ack !== 4'b1000 || req0 !== 1'b1) begin
        n_fail++; $display("FAIL glitch_hold%0d: ack=%b req0=%b want 1000/1", i, ack, req0);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  // Reference: a pending pick waits for the parent, a grant lasts until its request drops.
  task automatic test_random;
    int         last_m;
    int         chosen;
    int         granted;
    int         held;
    logic       err_m;
    logic [3:0] exp_ack;
    logic       exp_req0;
    do_reset();
    tie_root = 1'b0;
    last_m   = 3;
    chosen   = -1;
    granted  = -1;
    held     = 0;
    err_m    = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom());
      ack0_drv = 1'($urandom());
      if (granted >= 0) begin
        if (held == MAX_HOLD) err_m = 1'b1;
        else held++;
        if (!req[granted]) begin
          last_m  = granted;
          granted = -1;
        end
      end else if (chosen >= 0) begin
        if (ack0_drv) begin
          granted = chosen;
          chosen  = -1;
          held    = 0;
        end
      end else if (req != 4'b0000) begin
        for (int k = 4; k >= 1; k--) if (req[(last_m + k) % 4]) chosen = (last_m + k) % 4;
      end
      tick();
      exp_req0 = (chosen >= 0) || (granted >= 0);
      exp_ack  = (granted >= 0) ? 4'(1 << granted) : 4'b0000;
      n_checks++;
      if (ack !== exp_ack || req0 !== exp_req0 || hold_err !== err_m) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: ack=%b req0=%b hold_err=%b want %b/%b/%b",
                 c, ack, req0, hold_err, exp_ack, exp_req0, err_m);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    ack0_drv = 1'b0;
    tie_root = 1'b1;
    test_reset();
    test_basic();
    test_rotation();
    test_non_root();
    test_hold();
    test_reset_mid();
    test_ack0_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter MAX_HOLD, default 15, SHALL set the ack-cycle limit before hold_err is raised (legal 1..255).
REQ-002 Parameter CW, default 8, SHALL set the hold counter width; CW SHALL satisfy 2**CW > MAX_HOLD.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  4  SHALL carry the four-phase requests from children/clients 0..3.
REQ-006 ack  output  4  SHALL carry the grants to children, one-hot or zero.
REQ-007 req0  output  1  SHALL carry the request to the parent cell, or the root tie-off.
REQ-008 ack0  input  1  SHALL carry the grant from the parent; the root ties ack0 to req0.
REQ-009 hold_err  output  1  SHALL be a sticky flag: a grant was held beyond MAX_HOLD cycles.

Function
REQ-010 Control SHALL be a Moore FSM with states A_IDLE, A_REQ, A_ACK; all outputs SHALL be decoded from registers only.
REQ-011 A_IDLE with req!=0: SHALL latch winner w (2 bits) and go to A_REQ; with req==0 it SHALL stay in A_IDLE.
REQ-012 Winner SHALL be the first set req bit scanning last+1, last+2, last+3, last (mod 4), where last is the previous granted index.
REQ-013 A_REQ: SHALL go to A_ACK when ack0==1, otherwise stay; req changes in A_REQ SHALL NOT alter w.
REQ-014 A_ACK: SHALL go to A_IDLE and set last<=w when req[w]==0; otherwise stay.
REQ-015 Outputs: req0 = (A_REQ or A_ACK); ack[w] = A_ACK; all other ack bits SHALL be 0.
REQ-016 Latency: req sampled at edge t -> req0 high after t; ack0 sampled high at t+1 -> ack[w] high after t+1; with root tie-off, ack follows req by 2 edges.
REQ-017 Release: req[w] sampled low at edge t -> ack and req0 low after t; at least one A_IDLE cycle SHALL separate consecutive grants.
REQ-018 ack0 SHALL be ignored in A_IDLE and A_ACK, so a parent dropping ack0 early SHALL NOT revoke a grant.
REQ-019 Simultaneous requests: exactly one winner per REQ-012; losers SHALL wait with ack low; no client SHALL wait more than 3 grants.
REQ-020 hold_cnt SHALL be 0 on entry to A_ACK, increment each A_ACK cycle, and saturate at MAX_HOLD.
REQ-021 hold_err SHALL be set at the edge where state==A_ACK and hold_cnt==MAX_HOLD, and SHALL stay set until reset.

Reset
REQ-022 rst_n==0 at an edge SHALL force A_IDLE, last=3 (client 0 highest), w=0, hold_cnt=0, hold_err=0.
REQ-023 After reset, ack=0, req0=0, hold_err=0; a reset in A_REQ or A_ACK SHALL drop all grants after that edge with no release handshake.
REQ-024 Reset SHALL take priority over every transition, including a same-cycle req or ack0.

Structure
REQ-025 Package arb_pkg SHALL hold the ArbPhase enum (A_IDLE, A_REQ, A_ACK) and the constant N_CLIENTS=4.
REQ-026 Sub-module rr_pick (combinational: req[3:0], last[1:0] -> winner[1:0], any) SHALL implement REQ-012.
REQ-027 rr_arb4 instances SHALL compose into trees via req0/ack0 with no glue logic.

Verification
REQ-028 Reset, then req=0001 with root tie-off -> req0=1 after edge 1, ack=0001 after edge 2; req=0000 -> ack=0000, req0=0 next edge.
REQ-029 req=1111 held, each client releases 1 cycle after its ack -> grant order 0,1,2,3,0; ack never multi-hot.
REQ-030 Non-root: req=0100, ack0 held low 5 cycles then high -> ack stays 0000 for those 5 cycles; ack=0100 one edge after ack0 rises.
REQ-031 MAX_HOLD=15, grant held 20 cycles -> hold_err=0 through 16 A_ACK cycles, hold_err=1 from the 17th onward, hold_err still 1 after release.
REQ-032 rst_n low for one edge during A_ACK with ack=0010 -> ack=0000, req0=0, hold_err=0 after that edge; next req=1111 grants client 0.
REQ-033 ack0 pulses high during A_IDLE and low during A_ACK -> no state change and no grant loss.
